// File: rtl/cpu_branch_predictor_if.sv
// cpu_branch_predictor_if: fetch lookup, prediction and execute-update signals for the branch predictor
interface cpu_branch_predictor_if;
  logic        ready;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        predict_valid;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  modport master (
    input  ready, predict_valid, predict_taken, predict_target,
    output lookup_valid, lookup_pc, update_valid, update_pc, update_taken, update_target
  );
  modport slave (
    output ready, predict_valid, predict_taken, predict_target,
    input  lookup_valid, lookup_pc, update_valid, update_pc, update_taken, update_target
  );
endinterface

// File: rtl/cpu_branch_predictor.sv
// cpu_branch_predictor: direct-mapped 2-bit counter direction predictor with post-reset init sweep.
// Define CPU_BRANCH_PREDICTOR_BTB_EN to add per-entry valid, tag and target storage.
module cpu_branch_predictor #(
  parameter int INDEX_BITS = 6
) (
  input logic clk,
  input logic rst,
  cpu_branch_predictor_if.slave bp
);
  localparam int ENTRIES = 2 ** INDEX_BITS;
  typedef enum logic {INIT, READY} state_t;
  state_t                state;
  logic [INDEX_BITS-1:0] sweep_idx;
  logic                  ready;
  logic                  predict_valid;
  logic                  predict_taken;
  logic [1:0]            cnt [ENTRIES];
  logic [INDEX_BITS-1:0] l_idx;
  logic [INDEX_BITS-1:0] u_idx;
  logic [1:0]            u_base;
  logic [1:0]            u_next;
  logic                  l_taken;
  assign l_idx = bp.lookup_pc[INDEX_BITS+1:2];
  assign u_idx = bp.update_pc[INDEX_BITS+1:2];
  assign u_next = bp.update_taken ? (u_base == 2'b11 ? 2'b11 : u_base + 2'b01)
                                  : (u_base == 2'b00 ? 2'b00 : u_base - 2'b01);
  assign bp.ready         = ready;
  assign bp.predict_valid = predict_valid;
  assign bp.predict_taken = predict_taken;
`ifdef CPU_BRANCH_PREDICTOR_BTB_EN
  localparam int TAG_BITS = 30 - INDEX_BITS;
  logic                vld [ENTRIES];
  logic [TAG_BITS-1:0] tag [ENTRIES];
  logic [31:0]         tgt [ENTRIES];
  logic [31:0]         predict_target;
  logic                l_hit;
  logic                u_hit;
  logic                unused_bits;
  assign unused_bits = ^{bp.lookup_pc[1:0], bp.update_pc[1:0]};
  assign l_hit   = vld[l_idx] && tag[l_idx] == bp.lookup_pc[31:INDEX_BITS+2];
  assign u_hit   = vld[u_idx] && tag[u_idx] == bp.update_pc[31:INDEX_BITS+2];
  // A different branch taking over the entry starts from weakly not-taken.
  assign u_base  = u_hit ? cnt[u_idx] : 2'b01;
  assign l_taken = l_hit && cnt[l_idx][1];
  assign bp.predict_target = predict_target;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      predict_target <= '0;
    else if (state == READY && bp.lookup_valid)
      predict_target <= l_hit ? tgt[l_idx] : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      cnt[sweep_idx] <= 2'b01;
      vld[sweep_idx] <= 1'b0;
    end else if (bp.update_valid) begin
      cnt[u_idx] <= u_next;
      vld[u_idx] <= 1'b1;
      tag[u_idx] <= bp.update_pc[31:INDEX_BITS+2];
      tgt[u_idx] <= bp.update_target;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{bp.lookup_pc[31:INDEX_BITS+2], bp.lookup_pc[1:0],
                         bp.update_pc[31:INDEX_BITS+2], bp.update_pc[1:0], bp.update_target};
  assign u_base  = cnt[u_idx];
  assign l_taken = cnt[l_idx][1];
  assign bp.predict_target = 32'h0;
  always_ff @(posedge clk) begin
    if (state == INIT)
      cnt[sweep_idx] <= 2'b01;
    else if (bp.update_valid)
      cnt[u_idx] <= u_next;
  end
`endif
  // Lookups read the table before this edge's update lands, giving read-before-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= INIT;
      sweep_idx     <= '0;
      ready         <= 1'b0;
      predict_valid <= 1'b0;
      predict_taken <= 1'b0;
    end else if (state == INIT) begin
      sweep_idx     <= sweep_idx + 1'b1;
      predict_valid <= 1'b0;
      if (&sweep_idx) begin
        state <= READY;
        ready <= 1'b1;
      end
    end else begin
      predict_valid <= bp.lookup_valid;
      if (bp.lookup_valid)
        predict_taken <= l_taken;
    end
  end
endmodule
